// File: rtl/preproc_fifo_reader.sv
// preproc_fifo_reader: drains one N-sample DFT block from a show-ahead FIFO onto a registered valid/ready stream
`timescale 1ns/1ps
`ifndef FFT_IN_WIDTH
`define FFT_IN_WIDTH 16
`endif
module preproc_fifo_reader #(
  parameter int DATA_WIDTH = 2*`FFT_IN_WIDTH,
  parameter int LEN_WIDTH = 11
) (
  input  logic                  clk_sys,
  input  logic                  rst_sys_n,
  input  logic                  start_i,
  input  logic [LEN_WIDTH-1:0]  dft_len_i,
  input  logic                  abort_i,
  input  logic [DATA_WIDTH-1:0] fifo_dout_i,
  input  logic                  fifo_empty_i,
  output logic                  fifo_re_o,
  output logic                  fifo_clr_o,
  output logic [DATA_WIDTH-1:0] dout_o,
  output logic                  dout_valid_o,
  input  logic                  dout_ready_i,
  output logic                  sop_o,
  output logic                  eop_o,
  output logic                  busy_o,
  output logic                  done_o,
  output logic [15:0]           stall_cnt_o
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state, state_nxt;
  logic [LEN_WIDTH-1:0] len;
  logic [LEN_WIDTH:0] rd_cnt;
  logic can_load, pending, start_ok, hs;
  assign can_load = !dout_valid_o || dout_ready_i;
  // pending: the block still owes pops, so an empty FIFO here is starvation
  assign pending = (state == RUN) && (rd_cnt < {1'b0, len});
  assign start_ok = (state == IDLE) && start_i && !abort_i && (dft_len_i != '0);
  assign hs = dout_valid_o && dout_ready_i;
  assign fifo_re_o = pending && !fifo_empty_i && can_load && !abort_i;
  assign busy_o = state != IDLE;
  assign done_o = state == DONE;
  always_comb begin
    state_nxt = abort_i ? IDLE : start_ok ? RUN : (state == RUN && hs && eop_o) ? DONE : (state == DONE) ? IDLE : state;
  end
  always_ff @(posedge clk_sys or negedge rst_sys_n) begin
    if (!rst_sys_n) state <= IDLE;
    else state <= state_nxt;
  end
  always_ff @(posedge clk_sys or negedge rst_sys_n) begin
    if (!rst_sys_n) begin
      len <= '0;
      rd_cnt <= '0;
      fifo_clr_o <= 1'b0;
      dout_o <= '0;
      dout_valid_o <= 1'b0;
      sop_o <= 1'b0;
      eop_o <= 1'b0;
      stall_cnt_o <= '0;
    end else begin
      fifo_clr_o <= abort_i;
      if (start_ok) begin
        len <= dft_len_i;
        stall_cnt_o <= '0;
      end else if (pending && fifo_empty_i && can_load && stall_cnt_o != 16'hFFFF) begin
        stall_cnt_o <= stall_cnt_o + 16'd1;
      end
      if (abort_i || start_ok) rd_cnt <= '0;
      else if (fifo_re_o) rd_cnt <= rd_cnt + (LEN_WIDTH+1)'(1);
      if (abort_i) begin
        dout_valid_o <= 1'b0;
        sop_o <= 1'b0;
        eop_o <= 1'b0;
      end else if (fifo_re_o) begin
        dout_o <= fifo_dout_i;
        dout_valid_o <= 1'b1;
        sop_o <= rd_cnt == '0;
        eop_o <= rd_cnt == {1'b0, len} - (LEN_WIDTH+1)'(1);
      end else if (hs) begin
        dout_valid_o <= 1'b0;
        sop_o <= 1'b0;
        eop_o <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_preproc_fifo_reader.sv
// tb_preproc_fifo_reader: directed and randomized block reads against a queue-based FIFO and stream model
`timescale 1ns/1ps
module tb_preproc_fifo_reader;
  localparam int DW = 32;
  localparam int LW = 11;
  logic clk_sys = 1'b0, rst_sys_n = 1'b0, start_i = 1'b0, abort_i = 1'b0, dout_ready_i = 1'b0, fifo_empty_i = 1'b1;
  logic [LW-1:0] dft_len_i = '0;
  logic [DW-1:0] fifo_dout_i = '0;
  logic fifo_re_o, fifo_clr_o, dout_valid_o, sop_o, eop_o, busy_o, done_o;
  logic [DW-1:0] dout_o;
  logic [15:0] stall_cnt_o;
  logic [DW+22:0] outs;
  logic [DW-1:0] fq[$], pend[$], sent[$];
  logic [DW+1:0] got[$];
  logic [DW+1:0] pd = '0;
  logic pv = 1'b0;
  int pops = 0, dones = 0, bp_viol = 0, hold_viol = 0;
  int errs = 0, checks = 0;

  always #5 clk_sys = ~clk_sys;

  preproc_fifo_reader #(.DATA_WIDTH(DW), .LEN_WIDTH(LW)) dut (
    .clk_sys(clk_sys), .rst_sys_n(rst_sys_n), .start_i(start_i), .dft_len_i(dft_len_i),
    .abort_i(abort_i), .fifo_dout_i(fifo_dout_i), .fifo_empty_i(fifo_empty_i),
    .fifo_re_o(fifo_re_o), .fifo_clr_o(fifo_clr_o), .dout_o(dout_o), .dout_valid_o(dout_valid_o),
    .dout_ready_i(dout_ready_i), .sop_o(sop_o), .eop_o(eop_o), .busy_o(busy_o), .done_o(done_o),
    .stall_cnt_o(stall_cnt_o)
  );

  assign outs = {dout_o, dout_valid_o, sop_o, eop_o, busy_o, done_o, stall_cnt_o, fifo_clr_o, fifo_re_o};

  // show-ahead FIFO: clear, pop, then words pushed by the stimulus become visible after this edge
  always @(posedge clk_sys) begin
    if (fifo_clr_o) fq.delete();
    else if (fifo_re_o && fq.size() > 0) begin
      void'(fq.pop_front());
      pops <= pops + 1;
    end
    while (pend.size() > 0) fq.push_back(pend.pop_front());
    fifo_empty_i <= fq.size() == 0;
    fifo_dout_i <= (fq.size() > 0) ? fq[0] : '0;
  end

  // stream monitor: records transfers, done pulses and back-pressure rule breaches
  always @(negedge clk_sys) begin
    if (dout_valid_o && dout_ready_i) got.push_back({sop_o, eop_o, dout_o});
    if (done_o) dones <= dones + 1;
    if (fifo_re_o && dout_valid_o && !dout_ready_i) bp_viol <= bp_viol + 1;
    if (pv && rst_sys_n && (!dout_valid_o || {sop_o, eop_o, dout_o} != pd)) hold_viol <= hold_viol + 1;
    pv <= dout_valid_o && !dout_ready_i && !abort_i && rst_sys_n;
    pd <= {sop_o, eop_o, dout_o};
  end

  task automatic tick();
    @(posedge clk_sys);
    #2;
  endtask

  task automatic push(input logic [DW-1:0] w);
    pend.push_back(w);
    sent.push_back(w);
  endtask

  task automatic run_block(input string name, input int n, input int mode, input int feed, input int gap,
                           input bit chk_stall, input int exp_stall, input bit restart);
    int b_pop, b_done, b_bp, b_hold, fed, e, cyc;
    logic [DW-1:0] w;
    got.delete();
    b_pop = pops; b_done = dones; b_bp = bp_viol; b_hold = hold_viol;
    fed = 0; e = 0; cyc = 0;
    start_i = 1'b1; dft_len_i = LW'(n); dout_ready_i = 1'b1;
    tick();
    start_i = 1'b0;
    while (dones == b_done && cyc < 4000) begin
      if (restart && cyc == 0) begin
        start_i = 1'b1;
        dft_len_i = LW'(n + 5);
      end else start_i = 1'b0;
      if (cyc > 0) dout_ready_i = (mode == 0) ? 1'b1 : (mode == 1) ? ~dout_ready_i : 1'($urandom_range(0, 1));
      if (fifo_empty_i) e++;
      if (gap > 0) begin
        if (e == gap && fed == 0) repeat (feed) begin push($urandom); fed++; end
      end else if (fed < feed && $urandom_range(0, 1) == 1) begin
        push($urandom); fed++;
      end
      tick();
      cyc++;
    end
    start_i = 1'b0;
    dout_ready_i = 1'b1;
    checks++;
    if (cyc >= 4000) begin errs++; $display("FAIL %s_timeout got=no done_o exp=done_o within 4000 cycles", name); end
    checks++;
    if (got.size() != n) begin errs++; $display("FAIL %s_count got=%0d exp=%0d", name, got.size(), n); end
    for (int i = 0; i < n && i < got.size(); i++) begin
      w = '0;
      if (sent.size() > 0) w = sent.pop_front();
      checks++;
      if (got[i] !== {i == 0, i == n - 1, w}) begin
        errs++;
        $display("FAIL %s_sample%0d got={sop,eop,data}=%h exp=%h", name, i, got[i], {i == 0, i == n - 1, w});
      end
    end
    checks++;
    if (pops - b_pop != n) begin errs++; $display("FAIL %s_pops got=%0d exp=%0d", name, pops - b_pop, n); end
    checks++;
    if (bp_viol != b_bp) begin errs++; $display("FAIL %s_pop_while_blocked got=%0d exp=0", name, bp_viol - b_bp); end
    checks++;
    if (hold_viol != b_hold) begin errs++; $display("FAIL %s_hold got=%0d exp=0", name, hold_viol - b_hold); end
    if (chk_stall) begin
      checks++;
      if (stall_cnt_o !== 16'(exp_stall)) begin errs++; $display("FAIL %s_stall got=%0d exp=%0d", name, stall_cnt_o, exp_stall); end
    end
  endtask

  task automatic test_reset();
    rst_sys_n = 1'b0;
    tick(); tick();
    checks++;
    if (outs !== '0) begin errs++; $display("FAIL reset_outputs got=%h exp=0", outs); end
    rst_sys_n = 1'b1;
    tick();
    checks++;
    if (outs !== '0) begin errs++; $display("FAIL reset_release got=%h exp=0", outs); end
  endtask

  task automatic test_basic();
    int b_pop;
    for (int i = 1; i <= 4; i++) push(DW'(i));
    tick(); tick();
    b_pop = pops;
    start_i = 1'b1; dft_len_i = 4; dout_ready_i = 1'b1;
    tick();
    start_i = 1'b0;
    checks++;
    if ({dout_valid_o, busy_o, fifo_re_o} !== 3'b011) begin
      errs++; $display("FAIL basic_first_cycle got={valid,busy,re}=%b exp=011", {dout_valid_o, busy_o, fifo_re_o});
    end
    for (int i = 1; i <= 4; i++) begin
      tick();
      checks++;
      if ({dout_valid_o, sop_o, eop_o, dout_o} !== {1'b1, i == 1, i == 4, DW'(i)}) begin
        errs++;
        $display("FAIL basic_word%0d got={v,sop,eop,data}=%h exp=%h", i, {dout_valid_o, sop_o, eop_o, dout_o}, {1'b1, i == 1, i == 4, DW'(i)});
      end
      void'(sent.pop_front());
    end
    tick();
    checks++;
    if ({done_o, busy_o, dout_valid_o} !== 3'b110) begin
      errs++; $display("FAIL basic_done got={done,busy,valid}=%b exp=110", {done_o, busy_o, dout_valid_o});
    end
    tick();
    checks++;
    if ({done_o, busy_o} !== 2'b00) begin errs++; $display("FAIL basic_idle got={done,busy}=%b exp=00", {done_o, busy_o}); end
    checks++;
    if (stall_cnt_o !== 16'd0) begin errs++; $display("FAIL basic_stall got=%0d exp=0", stall_cnt_o); end
    checks++;
    if (pops - b_pop != 4) begin errs++; $display("FAIL basic_pops got=%0d exp=4", pops - b_pop); end
  endtask

  task automatic test_backpressure();
    for (int i = 0; i < 8; i++) push($urandom);
    tick(); tick();
    run_block("backpressure", 8, 1, 0, 0, 1'b1, 0, 1'b0);
  endtask

  task automatic test_starvation();
    for (int i = 0; i < 3; i++) push($urandom);
    tick(); tick();
    run_block("starvation", 6, 0, 3, 5, 1'b1, 5, 1'b0);
  endtask

  task automatic test_surplus();
    for (int i = 0; i < 7; i++) push($urandom);
    tick(); tick();
    run_block("surplus_a", 4, 0, 0, 0, 1'b1, 0, 1'b0);
    checks++;
    if (fq.size() != 3) begin errs++; $display("FAIL surplus_left got=%0d exp=3", fq.size()); end
    run_block("surplus_b", 3, 0, 0, 0, 1'b1, 0, 1'b0);
  endtask

  task automatic test_corners();
    int b_pop;
    push($urandom); push($urandom);
    tick(); tick();
    b_pop = pops;
    start_i = 1'b1; dft_len_i = 0;
    tick();
    start_i = 1'b0;
    checks++;
    if (busy_o !== 1'b0) begin errs++; $display("FAIL zero_len_busy got=%b exp=0", busy_o); end
    tick();
    checks++;
    if ({busy_o, fifo_re_o} !== 2'b00) begin errs++; $display("FAIL zero_len_idle got={busy,re}=%b exp=00", {busy_o, fifo_re_o}); end
    checks++;
    if (pops != b_pop || fq.size() != 2) begin errs++; $display("FAIL zero_len_fifo got=pops %0d size %0d exp=pops 0 size 2", pops - b_pop, fq.size()); end
    run_block("n1", 1, 0, 0, 0, 1'b1, 0, 1'b0);
    for (int i = 0; i < 3; i++) push($urandom);
    tick(); tick();
    run_block("start_busy", 4, 0, 0, 0, 1'b1, 0, 1'b1);
  endtask

  task automatic test_abort();
    int b_done, cyc;
    logic [DW-1:0] w;
    for (int i = 0; i < 10; i++) push($urandom);
    tick(); tick();
    got.delete();
    b_done = dones;
    start_i = 1'b1; dft_len_i = 10; dout_ready_i = 1'b1;
    tick();
    start_i = 1'b0;
    cyc = 0;
    while (got.size() < 3 && cyc < 100) begin tick(); cyc++; end
    checks++;
    if (cyc >= 100) begin errs++; $display("FAIL abort_wait got=%0d transfers exp=3", got.size()); end
    abort_i = 1'b1; start_i = 1'b1; dft_len_i = 5;
    #1;
    checks++;
    if (fifo_re_o !== 1'b0) begin errs++; $display("FAIL abort_no_pop got=%b exp=0", fifo_re_o); end
    tick();
    abort_i = 1'b0; start_i = 1'b0;
    checks++;
    if ({fifo_clr_o, dout_valid_o, sop_o, eop_o, busy_o} !== 5'b10000) begin
      errs++; $display("FAIL abort_next got={clr,valid,sop,eop,busy}=%b exp=10000", {fifo_clr_o, dout_valid_o, sop_o, eop_o, busy_o});
    end
    tick();
    checks++;
    if ({fifo_clr_o, busy_o} !== 2'b00) begin errs++; $display("FAIL abort_pulse got={clr,busy}=%b exp=00", {fifo_clr_o, busy_o}); end
    checks++;
    if (dones != b_done) begin errs++; $display("FAIL abort_no_done got=%0d exp=0", dones - b_done); end
    checks++;
    if (fq.size() != 0) begin errs++; $display("FAIL abort_flush got=%0d exp=0", fq.size()); end
    for (int i = 0; i < 3; i++) begin
      w = sent[i];
      checks++;
      if (got[i] !== {i == 0, 1'b0, w}) begin errs++; $display("FAIL abort_word%0d got=%h exp=%h", i, got[i], {i == 0, 1'b0, w}); end
    end
    sent.delete();
    abort_i = 1'b1;
    tick();
    abort_i = 1'b0;
    checks++;
    if ({fifo_clr_o, busy_o, done_o} !== 3'b100) begin
      errs++; $display("FAIL abort_idle got={clr,busy,done}=%b exp=100", {fifo_clr_o, busy_o, done_o});
    end
    tick();
    checks++;
    if (fifo_clr_o !== 1'b0) begin errs++; $display("FAIL abort_idle_pulse got=%b exp=0", fifo_clr_o); end
  endtask

  task automatic test_random();
    int n, pre;
    for (int b = 0; b < 6; b++) begin
      n = $urandom_range(1, 24);
      pre = $urandom_range(0, n);
      for (int i = 0; i < pre; i++) push($urandom);
      tick(); tick();
      run_block($sformatf("random%0d", b), n, 2, n - pre, 0, 1'b0, 0, 1'b0);
    end
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 5; i++) push($urandom);
    tick(); tick();
    start_i = 1'b1; dft_len_i = 5; dout_ready_i = 1'b0;
    tick();
    start_i = 1'b0;
    tick(); tick();
    checks++;
    if ({busy_o, dout_valid_o} !== 2'b11) begin errs++; $display("FAIL reset_mid_pre got={busy,valid}=%b exp=11", {busy_o, dout_valid_o}); end
    rst_sys_n = 1'b0;
    #1;
    checks++;
    if (outs !== '0) begin errs++; $display("FAIL reset_mid_outputs got=%h exp=0", outs); end
    tick();
    rst_sys_n = 1'b1;
    tick();
    checks++;
    if (outs !== '0) begin errs++; $display("FAIL reset_mid_after got=%h exp=0", outs); end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_starvation();
    test_surplus();
    test_corners();
    test_abort();
    test_random();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule

// File: doc/preproc_fifo_reader.md
# preproc_fifo_reader

Read-side controller for the pre-processing sample FIFO. It drains exactly one DFT block of N complex samples from the show-ahead FIFO and presents them to the DFT datapath on a registered valid/ready stream, with start-of-block and end-of-block markers. It also counts stall cycles caused by FIFO starvation and can abort a block and flush the FIFO.

## Interface
Parameters:
- DATA_WIDTH, 2*`FFT_IN_WIDTH, packed {re, im} sample width; matches the FIFO data width.
- LEN_WIDTH, 11, width of the block-length field; supports N = 1..2047.

Ports:
- clk_sys  in  1  system clock, rising edge.
- rst_sys_n  in  1  asynchronous, active-low reset.
- start_i  in  1  one-cycle pulse; latches dft_len_i and begins a block.
- dft_len_i  in  LEN_WIDTH  block length N; sampled only on an accepted start_i.
- abort_i  in  1  one-cycle pulse; cancels the block and flushes the FIFO.
- fifo_dout_i  in  DATA_WIDTH  FIFO head word; valid whenever fifo_empty_i=0.
- fifo_empty_i  in  1  FIFO empty flag.
- fifo_re_o  out  1  FIFO pop; combinational.
- fifo_clr_o  out  1  FIFO synchronous clear; registered one-cycle pulse.
- dout_o  out  DATA_WIDTH  output sample, registered.
- dout_valid_o  out  1  output sample valid.
- dout_ready_i  in  1  downstream accept.
- sop_o  out  1  qualifies the first sample of a block; meaningful only with dout_valid_o.
- eop_o  out  1  qualifies the last sample of a block; meaningful only with dout_valid_o.
- busy_o  out  1  state != IDLE.
- done_o  out  1  one-cycle pulse after the last sample is accepted.
- stall_cnt_o  out  16  starvation cycle counter; saturates at 0xFFFF.

## Operation
States are IDLE, RUN and DONE.
- **IDLE**
  - start_i=1, abort_i=0 and dft_len_i!=0: latch len=N, clear rd_cnt, clear stall_cnt_o, then go to RUN.
  - start_i with dft_len_i=0 is ignored.
  - start_i is also ignored in RUN and DONE.
- **RUN**
  - Define can_load = !dout_valid_o | dout_ready_i.
  - fifo_re_o = RUN & !fifo_empty_i & (rd_cnt < len) & can_load & !abort_i.
  - On fifo_re_o:
    - dout_o <= fifo_dout_i and dout_valid_o <= 1.
    - sop_o <= (rd_cnt==0) and eop_o <= (rd_cnt==len-1).
    - rd_cnt increments.
  - On handshake (valid & ready) with no simultaneous load: dout_valid_o <= 0, sop_o <= 0, eop_o <= 0.
  - Handshake on a sample with eop_o=1: go to DONE.
  - Stall cycle: RUN & fifo_empty_i & (rd_cnt < len) & can_load. Each stall cycle increments stall_cnt_o, saturating.
  - Back-pressure (dout_ready_i=0 with dout_valid_o=1):
    - Hold dout_o, sop_o and eop_o stable.
    - No pop occurs.
    - This is not a stall.
- **DONE**
  - done_o=1 for exactly this one cycle.
  - fifo_re_o=0.
  - Next state is IDLE unconditionally.
- **Abort** (any state, including IDLE)
  - Next state is IDLE.
  - dout_valid_o, sop_o and eop_o clear.
  - rd_cnt clears.
  - fifo_clr_o=1 for one cycle.
  - done_o is not asserted.
  - abort_i wins over a simultaneous start_i, a pop, or a handshake. A handshake in that cycle counts as a transfer to downstream, but the block is still not done.
- **Counters**
  - rd_cnt is LEN_WIDTH+1 bits wide, so rd_cnt==len is representable without wrap.
  - stall_cnt_o holds its value until the next accepted start_i.

## Timing
- **Reset values:** every output is 0 (dout_o=0, stall_cnt_o=0) and the state is IDLE. Reset asserted mid-block clears all of this immediately; fifo_clr_o is not generated by reset.
- **Start:** start_i accepted at edge k puts the block in RUN from k+1. The first fifo_re_o can assert in the cycle after k. The first dout_valid_o appears at k+2.
- **Latency:** pop-to-output is 1 cycle.
- **Throughput:** 1 sample/cycle when the FIFO is non-empty and dout_ready_i=1 continuously.
- **Done:** the eop handshake at edge e gives done_o=1 and busy_o=1 in cycle e..e+1. busy_o=0 from e+1 onward, and the next start can be accepted at edge e+2.
- **Abort:** abort_i at edge a gives fifo_clr_o high for cycle a..a+1 and busy_o=0 after a.
- **Pops per block:** exactly N. Surplus FIFO words stay in the FIFO for the next block.

## Test plan
- **Basic block:** reset, prefill FIFO with 0x0001..0x0004, start with N=4, ready=1.
  - Output 0x0001..0x0004 on 4 consecutive cycles starting 2 cycles after start.
  - sop_o only on 0x0001, eop_o only on 0x0004.
  - done_o one cycle after the last handshake.
  - stall_cnt_o=0.
- **Back-pressure:** N=8, dout_ready_i toggling 1/0 each cycle.
  - All 8 words appear in order, each held while ready=0.
  - fifo_re_o is never high while the output is full and ready=0.
  - Exactly 8 pops.
- **Starvation:** N=6, the FIFO receives 3 words, then nothing for 5 cycles, then 3 more.
  - Order is preserved.
  - stall_cnt_o=5.
  - done_o fires after word 6.
- **Surplus data:** FIFO holds 7 words, start with N=4.
  - Exactly 4 pops.
  - The FIFO still holds 3 words after done_o.
  - A second start with N=3 outputs the remaining 3, with sop_o on the first.
- **Abort:** N=10, abort_i after 3 handshakes.
  - fifo_clr_o is a one-cycle pulse.
  - dout_valid_o=0 the next cycle, busy_o=0, no done_o.
  - A start in the same cycle as the abort is ignored.
- **Corner cases:**
  - start with N=0 does nothing.
  - start while busy is ignored.
  - N=1 asserts sop_o and eop_o on the same sample.
  - Reset asserted mid-block returns all outputs to 0.
